// File: rtl/konami_button_events_pkg.sv
`default_nettype none
// ============================================================================
// Module   : konami_pkg
// Brief    : Button indices, vector type and helpers for the button front end.
// Revision : 1.0 - initial release
// ============================================================================
package konami_pkg;

  localparam int c_num_buttons = 7;

  // Index order also fixes the mapping onto the recogniser's up_i/unup_i ... ports.
  typedef enum logic [2:0] {
    BTN_UP    = 3'd0,
    BTN_DOWN  = 3'd1,
    BTN_LEFT  = 3'd2,
    BTN_RIGHT = 3'd3,
    BTN_B     = 3'd4,
    BTN_A     = 3'd5,
    BTN_START = 3'd6
  } button_e;

  typedef logic [c_num_buttons-1:0] btn_vec_t;

  function automatic btn_vec_t btn_mask(button_e b);
    return btn_vec_t'(1) << b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/konami_button_events_if.sv
`default_nettype none
// ============================================================================
// Module   : konami_button_events_if
// Brief    : Raw button levels in, serialised press/release events out.
// Revision : 1.0 - initial release
// ============================================================================
interface konami_button_events_if;
  import konami_pkg::*;

  btn_vec_t raw_i;
  btn_vec_t press_o;
  btn_vec_t release_o;
  btn_vec_t level_o;
  logic     overflow_o;

  modport master (
    output raw_i,
    input  press_o,
    input  release_o,
    input  level_o,
    input  overflow_o
  );

  modport slave (
    input  raw_i,
    output press_o,
    output release_o,
    output level_o,
    output overflow_o
  );

endinterface
`default_nettype wire

// File: rtl/konami_button_events_button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : button_debounce
// Brief    : 2-flop synchroniser plus counter debounce for one button.
// Revision : 1.0 - initial release
// ============================================================================
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  wire logic clk_i,
  input  wire logic reset_i,
  input  wire logic raw_i,
  output logic      level_o,
  output logic      rise_o,
  output logic      fall_o
);

  localparam int                 c_cnt_w   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic               r_sync_q1;
  logic               r_sync_q2;
  logic               r_level;
  logic [c_cnt_w-1:0] r_cnt;
  logic               w_toggle;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_sync_q1 <= 1'b0;
      r_sync_q2 <= 1'b0;
    end else begin
      r_sync_q1 <= raw_i;
      r_sync_q2 <= r_sync_q1;
    end
  end

  // Level flips on the edge where the disagreement reaches its required run length.
  assign w_toggle = (r_sync_q2 != r_level) && (r_cnt == c_cnt_max);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (r_sync_q2 == r_level) begin
      r_cnt <= '0;
    end else if (w_toggle) begin
      r_cnt   <= '0;
      r_level <= ~r_level;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign level_o = r_level;
  assign rise_o  = w_toggle & ~r_level;
  assign fall_o  = w_toggle &  r_level;

endmodule
`default_nettype wire

// File: rtl/konami_button_events.sv
`default_nettype none
// ============================================================================
// Module   : konami_button_events
// Brief    : Debounces 7 buttons and emits at most one press/release per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module konami_button_events
  import konami_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  wire logic              clk_i,
  input  wire logic              reset_i,
  konami_button_events_if.slave  bus
);

  localparam int c_num_req = 2 * c_num_buttons;

  btn_vec_t               w_level;
  btn_vec_t               w_rise;
  btn_vec_t               w_fall;
  btn_vec_t               r_pend_press;
  btn_vec_t               r_pend_release;
  btn_vec_t               r_press;
  btn_vec_t               r_release;
  logic                   r_overflow;
  logic [c_num_req-1:0]   w_req;
  logic [c_num_req-1:0]   w_grant;
  logic [c_num_req-1:0]   w_set;
  logic [c_num_req-1:0]   w_next;
  logic                   w_overflow;

  for (genvar i = 0; i < c_num_buttons; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .raw_i   (bus.raw_i[i]),
      .level_o (w_level[i]),
      .rise_o  (w_rise[i]),
      .fall_o  (w_fall[i])
    );
  end

  // Releases occupy the low half so lowest-set-bit selection favours them.
  assign w_req   = {r_pend_press, r_pend_release};
  assign w_set   = {w_rise, w_fall};
  assign w_grant = w_req & (~w_req + 1'b1);

  // A fresh event wins over the grant that clears the same bit.
  assign w_next     = (w_req & ~w_grant) | w_set;
  assign w_overflow = |(w_set & w_req & ~w_grant);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_pend_press   <= '0;
      r_pend_release <= '0;
      r_press        <= '0;
      r_release      <= '0;
      r_overflow     <= 1'b0;
    end else begin
      r_pend_press   <= w_next[c_num_req-1:c_num_buttons];
      r_pend_release <= w_next[c_num_buttons-1:0];
      r_press        <= w_grant[c_num_req-1:c_num_buttons];
      r_release      <= w_grant[c_num_buttons-1:0];
      if (w_overflow) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.press_o    = r_press;
  assign bus.release_o  = r_release;
  assign bus.level_o    = w_level;
  assign bus.overflow_o = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_konami_button_events.sv
`default_nettype none
// ============================================================================
// Module   : tb_konami_button_events
// Brief    : Scoreboard bench for the button event front end (D=4 and D=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_konami_button_events;
  import konami_pkg::*;

  localparam int c_d_a = 4;
  localparam int c_d_b = 1;

  typedef struct {
    bit rel;
    int idx;
    int cyc;
  } evt_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  evt_t qa[$];
  evt_t qb[$];
  evt_t ea;
  evt_t eb;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  konami_button_events_if ifa ();
  konami_button_events_if ifb ();

  konami_button_events #(.DEBOUNCE_CYCLES(c_d_a)) dut_a (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (ifa)
  );

  konami_button_events #(.DEBOUNCE_CYCLES(c_d_b)) dut_b (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (ifb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] bitv(input int idx);
    return 32'(1) << idx;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input bit rel, input int idx, input int at);
    evt_t e;
    e.rel = rel; e.idx = idx; e.cyc = at;
    qa.push_back(e);
  endtask

  task automatic push_b(input bit rel, input int idx, input int at);
    evt_t e;
    e.rel = rel; e.idx = idx; e.cyc = at;
    qb.push_back(e);
  endtask

  task automatic drain(input bit use_b);
    int n = 0;
    while (((use_b ? qb.size() : qa.size()) != 0) && n < 200) begin
      tick();
      n++;
    end
    if (use_b && qb.size() != 0) begin
      check("b_drain_timeout", 32'(qb.size()), 0);
      qb.delete();
    end
    if (!use_b && qa.size() != 0) begin
      check("a_drain_timeout", 32'(qa.size()), 0);
      qa.delete();
    end
    repeat (12) tick();
  endtask

  // Output monitors: every observed event must match the head of its queue.
  always @(negedge clk) begin
    if ((ifa.press_o | ifa.release_o) != '0) begin
      check("a_onehot", 32'($countones({ifa.press_o, ifa.release_o}) <= 1), 1);
      if (qa.size() == 0) begin
        check("a_unexpected", 32'({ifa.release_o, ifa.press_o}), 0);
      end else begin
        ea = qa.pop_front();
        check("a_press",   32'(ifa.press_o),   ea.rel ? 32'(0) : bitv(ea.idx));
        check("a_release", 32'(ifa.release_o), ea.rel ? bitv(ea.idx) : 32'(0));
        check("a_cycle",   32'(cyc),           32'(ea.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if ((ifb.press_o | ifb.release_o) != '0) begin
      check("b_onehot", 32'($countones({ifb.press_o, ifb.release_o}) <= 1), 1);
      if (qb.size() == 0) begin
        check("b_unexpected", 32'({ifb.release_o, ifb.press_o}), 0);
      end else begin
        eb = qb.pop_front();
        check("b_press",   32'(ifb.press_o),   eb.rel ? 32'(0) : bitv(eb.idx));
        check("b_release", 32'(ifb.release_o), eb.rel ? bitv(eb.idx) : 32'(0));
        check("b_cycle",   32'(cyc),           32'(eb.cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst       = 1'b1;
    ifa.raw_i = '0;
    ifb.raw_i = '0;
    repeat (3) tick();
    check("rst_level",    32'(ifa.level_o),    0);
    check("rst_press",    32'(ifa.press_o),    0);
    check("rst_release",  32'(ifa.release_o),  0);
    check("rst_overflow", 32'(ifa.overflow_o), 0);
    check("rst_b_ovf",    32'(ifb.overflow_o), 0);
    rst = 1'b0;
    repeat (2) tick();

    // Clean press and release of UP, with level timing.
    n = cyc;
    ifa.raw_i = btn_mask(BTN_UP);
    push_a(0, int'(BTN_UP), n + 7);
    repeat (5) tick();
    check("level_up_early", 32'(ifa.level_o[0]), 0);
    tick();
    check("level_up_edge6", 32'(ifa.level_o[0]), 1);
    drain(0);
    n = cyc;
    ifa.raw_i = '0;
    push_a(1, int'(BTN_UP), n + 7);
    drain(0);
    check("level_up_released", 32'(ifa.level_o), 0);

    // Bounce on LEFT, then a 3-cycle glitch that must be ignored.
    for (int i = 0; i < 4; i++) begin
      ifa.raw_i = (i % 2 == 0) ? btn_mask(BTN_LEFT) : '0;
      tick();
    end
    n = cyc;
    ifa.raw_i = btn_mask(BTN_LEFT);
    push_a(0, int'(BTN_LEFT), n + 7);
    drain(0);
    check("level_left", 32'(ifa.level_o), 32'(btn_mask(BTN_LEFT)));
    ifa.raw_i = '0;
    repeat (3) tick();
    ifa.raw_i = btn_mask(BTN_LEFT);
    repeat (15) tick();
    check("glitch_level", 32'(ifa.level_o), 32'(btn_mask(BTN_LEFT)));
    n = cyc;
    ifa.raw_i = '0;
    push_a(1, int'(BTN_LEFT), n + 7);
    drain(0);

    // All seven buttons change together: serialised by index.
    n = cyc;
    ifa.raw_i = 7'h7f;
    for (int i = 0; i < c_num_buttons; i++) push_a(0, i, n + 7 + i);
    drain(0);
    check("level_all", 32'(ifa.level_o), 32'h7f);
    n = cyc;
    ifa.raw_i = '0;
    for (int i = 0; i < c_num_buttons; i++) push_a(1, i, n + 7 + i);
    drain(0);

    // RIGHT release and B press accepted together: release first.
    n = cyc;
    ifa.raw_i = btn_mask(BTN_RIGHT);
    push_a(0, int'(BTN_RIGHT), n + 7);
    drain(0);
    n = cyc;
    ifa.raw_i = btn_mask(BTN_B);
    push_a(1, int'(BTN_RIGHT), n + 7);
    push_a(0, int'(BTN_B), n + 8);
    drain(0);
    n = cyc;
    ifa.raw_i = '0;
    push_a(1, int'(BTN_B), n + 7);
    drain(0);

    // Asynchronous reset with events pending, then fresh debounce of held buttons.
    n = cyc;
    ifa.raw_i = 7'b0000111;
    push_a(0, int'(BTN_UP), n + 7);
    repeat (7) tick();
    check("press_before_reset", 32'(ifa.press_o), 32'(btn_mask(BTN_UP)));
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_press",    32'(ifa.press_o),    0);
    check("async_release",  32'(ifa.release_o),  0);
    check("async_level",    32'(ifa.level_o),    0);
    check("async_overflow", 32'(ifa.overflow_o), 0);
    repeat (2) tick();
    rst = 1'b0;
    n = cyc;
    for (int i = 0; i < 3; i++) push_a(0, i, n + 7 + i);
    drain(0);
    n = cyc;
    ifa.raw_i = '0;
    for (int i = 0; i < 3; i++) push_a(1, i, n + 7 + i);
    drain(0);
    check("a_overflow_clear", 32'(ifa.overflow_o), 0);

    // Overflow with D=1: UP re-pressed while its press waits behind releases.
    n = cyc;
    ifb.raw_i = 7'b1111110;
    for (int i = 1; i < c_num_buttons; i++) push_b(0, i, n + 3 + i);
    drain(1);
    check("b_overflow_pre", 32'(ifb.overflow_o), 0);
    n = cyc;
    ifb.raw_i = btn_mask(BTN_UP);
    push_b(1, 1, n + 4);
    push_b(1, 0, n + 5);
    for (int i = 2; i < c_num_buttons; i++) push_b(1, i, n + 4 + i);
    push_b(0, 0, n + 11);
    tick();
    ifb.raw_i = '0;
    tick();
    ifb.raw_i = btn_mask(BTN_UP);
    repeat (4) tick();
    check("b_overflow_set", 32'(ifb.overflow_o), 1);
    drain(1);
    check("b_overflow_sticky", 32'(ifb.overflow_o), 1);
    check("b_level_final",     32'(ifb.level_o),    32'(btn_mask(BTN_UP)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
